// File: rtl/sram_bist_ctrl.sv
// Two-pass write/read-compare BIST initiator for a single-port RAM.
// Pass 0 writes and checks P(addr), pass 1 writes and checks ~P(addr).
module sram_bist_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            pattern_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic                  ram_cs,
  output logic                  ram_wr_en,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR0, S_RD0, S_DRAIN0, S_WR1, S_RD1, S_DRAIN1, S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
  localparam logic [2:0]            DRAIN_LAST = 3'(RD_LATENCY - 1);

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic [2:0]            r_drain, w_drain_next;
  logic [1:0]            r_sel, w_sel_next;
  logic                  w_start_run;

  logic                  r_cs, r_wr_en, r_rd_en;
  logic [ADDR_WIDTH-1:0] r_ram_address;
  logic [DATA_WIDTH-1:0] r_ram_data_in;
  logic                  w_cs_next, w_wr_next, w_rd_next;
  logic [DATA_WIDTH-1:0] w_wr_data, w_rd_exp;

  logic                  r_pv    [RD_LATENCY];
  logic [DATA_WIDTH-1:0] r_pexp  [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] r_paddr [RD_LATENCY];
  logic                  w_mis;

  logic [7:0]            r_err;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [DATA_WIDTH-1:0] r_fail_data;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] sel,
                                                    input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] p;
    p = '0;
    case (sel)
      2'd0:    for (int i = 0; i < DATA_WIDTH; i++) p[i] = (i % 2 == 0);
      2'd1:    p = DATA_WIDTH'(a);
      2'd2:    p = '0;
      default: p = '1;
    endcase
    return p;
  endfunction

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_drain_next = r_drain;
    w_start_run  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next = S_WR0;
          w_addr_next  = '0;
          w_start_run  = 1'b1;
        end
      end
      S_WR0, S_RD0, S_WR1, S_RD1: begin
        w_addr_next  = r_addr + 1'b1;
        w_drain_next = '0;
        if (r_addr == LAST_ADDR) begin
          case (r_state)
            S_WR0:   w_state_next = S_RD0;
            S_RD0:   w_state_next = S_DRAIN0;
            S_WR1:   w_state_next = S_RD1;
            default: w_state_next = S_DRAIN1;
          endcase
        end
      end
      S_DRAIN0, S_DRAIN1: begin
        w_drain_next = r_drain + 1'b1;
        if (r_drain == DRAIN_LAST)
          w_state_next = (r_state == S_DRAIN0) ? S_WR1 : S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // abort wins over start and over every sequencing decision
    if (abort) begin
      w_state_next = S_IDLE;
      w_addr_next  = '0;
      w_start_run  = 1'b0;
    end
  end

  // RAM port values are derived from the next state so the registered port
  // always carries the access belonging to the current state/address.
  always_comb begin
    w_sel_next = w_start_run ? pattern_sel : r_sel;
    w_wr_next  = (w_state_next == S_WR0) || (w_state_next == S_WR1);
    w_rd_next  = (w_state_next == S_RD0) || (w_state_next == S_RD1);
    w_cs_next  = w_wr_next || w_rd_next;
    w_wr_data  = '0;
    if (w_wr_next)
      w_wr_data = pattern(w_sel_next, w_addr_next) ^ {DATA_WIDTH{w_state_next == S_WR1}};
    w_rd_exp = pattern(r_sel, r_ram_address) ^ {DATA_WIDTH{r_state == S_RD1}};
    w_mis    = r_pv[RD_LATENCY-1] && !abort && (ram_data_out != r_pexp[RD_LATENCY-1]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_drain       <= '0;
      r_sel         <= '0;
      r_cs          <= 1'b0;
      r_wr_en       <= 1'b0;
      r_rd_en       <= 1'b0;
      r_ram_address <= '0;
      r_ram_data_in <= '0;
    end else begin
      r_state       <= w_state_next;
      r_addr        <= w_addr_next;
      r_drain       <= w_drain_next;
      r_sel         <= w_sel_next;
      r_cs          <= w_cs_next;
      r_wr_en       <= w_wr_next;
      r_rd_en       <= w_rd_next;
      r_ram_address <= w_cs_next ? w_addr_next : '0;
      r_ram_data_in <= w_wr_data;
    end
  end

  // Read-compare delay line: one stage per cycle of RAM read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pv[i]    <= 1'b0;
        r_pexp[i]  <= '0;
        r_paddr[i] <= '0;
      end
    end else begin
      r_pv[0]    <= r_cs && r_rd_en && !abort;
      r_pexp[0]  <= w_rd_exp;
      r_paddr[0] <= r_ram_address;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pv[i]    <= r_pv[i-1] && !abort;
        r_pexp[i]  <= r_pexp[i-1];
        r_paddr[i] <= r_paddr[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err       <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else if (w_start_run) begin
      r_err       <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else if (w_mis) begin
      if (r_err != 8'hFF) r_err <= r_err + 8'd1;
      if (r_err == 8'd0) begin
        r_fail_addr <= r_paddr[RD_LATENCY-1];
        r_fail_data <= ram_data_out;
      end
    end
  end

  assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done        = (r_state == S_DONE);
  assign pass        = done && (r_err == 8'd0);
  assign err_count   = r_err;
  assign fail_addr   = r_fail_addr;
  assign fail_data   = r_fail_data;
  assign ram_cs      = r_cs;
  assign ram_wr_en   = r_wr_en;
  assign ram_rd_en   = r_rd_en;
  assign ram_address = r_ram_address;
  assign ram_data_in = r_ram_data_in;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Directed bench for sram_bist_ctrl: unit A (RD_LATENCY=1) with a fault-injecting
// RAM model, unit B (RD_LATENCY=3) with a clean RAM for reset/ignored-start timing.
module tb_sram_bist_ctrl;

  logic clk;
  logic reset_n_a, reset_n_b;
  logic start_a, start_b, abort_a, abort_b;
  logic [1:0] pattern_sel;

  logic       busy_a, done_a, pass_a, ram_cs_a, ram_wr_en_a, ram_rd_en_a;
  logic [7:0] err_count_a, fail_data_a, ram_data_in_a, ram_data_out_a;
  logic [5:0] fail_addr_a, ram_address_a;
  logic [2:0] dbg_state_a;

  logic       busy_b, done_b, pass_b, ram_cs_b, ram_wr_en_b, ram_rd_en_b;
  logic [7:0] err_count_b, fail_data_b, ram_data_in_b, ram_data_out_b;
  logic [5:0] fail_addr_b, ram_address_b;
  logic [2:0] dbg_state_b;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_bist_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .RD_LATENCY(1)) dut_a (
    .clk(clk), .reset_n(reset_n_a), .start(start_a), .abort(abort_a),
    .pattern_sel(pattern_sel), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_count_a), .fail_addr(fail_addr_a), .fail_data(fail_data_a),
    .ram_cs(ram_cs_a), .ram_wr_en(ram_wr_en_a), .ram_rd_en(ram_rd_en_a),
    .ram_address(ram_address_a), .ram_data_in(ram_data_in_a),
    .ram_data_out(ram_data_out_a), .dbg_state(dbg_state_a));

  sram_bist_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .RD_LATENCY(3)) dut_b (
    .clk(clk), .reset_n(reset_n_b), .start(start_b), .abort(abort_b),
    .pattern_sel(pattern_sel), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_count_b), .fail_addr(fail_addr_b), .fail_data(fail_data_b),
    .ram_cs(ram_cs_b), .ram_wr_en(ram_wr_en_b), .ram_rd_en(ram_rd_en_b),
    .ram_address(ram_address_b), .ram_data_in(ram_data_in_b),
    .ram_data_out(ram_data_out_b), .dbg_state(dbg_state_b));

  // ---------------- RAM models ----------------
  // fault_mode: 0 clean, 1 bit0 stuck-at-1 at addr 5, 2 data_out forced FF,
  // 3 address bit 3 shorted to 0.
  int         fault_mode = 0;
  logic [7:0] mem_a [64];
  logic [5:0] ea_a;
  assign ea_a = (fault_mode == 3) ? (ram_address_a & 6'b110111) : ram_address_a;

  always @(posedge clk) begin
    if (ram_cs_a && ram_wr_en_a) mem_a[ea_a] <= ram_data_in_a;
    if (ram_cs_a && ram_rd_en_a) begin
      if (fault_mode == 2)                    ram_data_out_a <= 8'hFF;
      else if (fault_mode == 1 && ea_a == 5)  ram_data_out_a <= mem_a[ea_a] | 8'h01;
      else                                    ram_data_out_a <= mem_a[ea_a];
    end
  end

  logic [7:0] mem_b [64];
  logic [7:0] rd1_b, rd2_b;
  always @(posedge clk) begin
    if (ram_cs_b && ram_wr_en_b) mem_b[ram_address_b] <= ram_data_in_b;
    if (ram_cs_b && ram_rd_en_b) rd1_b <= mem_b[ram_address_b];
    rd2_b          <= rd1_b;
    ram_data_out_b <= rd2_b;
  end

  // ---------------- scoreboard ----------------
  logic [13:0] exp_q[$];
  logic [13:0] sb_e;
  bit          sb_en = 1'b0;
  int          rd_cnt = 0;
  int          ovl_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_en) begin
      if (ram_wr_en_a && ram_rd_en_a) ovl_cnt++;
      if (!ram_cs_a && (ram_wr_en_a || ram_rd_en_a)) ovl_cnt++;
      if (ram_cs_a && ram_rd_en_a) rd_cnt++;
      if (ram_cs_a && ram_wr_en_a) begin
        if (exp_q.size() == 0) check("sb_extra_write", 32'({ram_address_a, ram_data_in_a}), 0);
        else begin
          sb_e = exp_q.pop_front();
          check("sb_write", 32'({ram_address_a, ram_data_in_a}), 32'(sb_e));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic start_run(input bit on_b, input logic [1:0] sel);
    @(negedge clk);
    pattern_sel = sel;
    if (on_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Counts edges after the start edge until done; expiry counts as a failure.
  task automatic wait_done(input bit on_b, input int max, output int n);
    n = 0;
    while (n < max) begin
      @(posedge clk);
      #1;
      n++;
      if (on_b ? done_b : done_a) break;
    end
    if (!(on_b ? done_b : done_a)) check("done_timeout", 0, 1);
  endtask

  task automatic check_result_a(input string tag, input int p, input int e,
                                input int fa, input int fd);
    check({tag, "_pass"},      32'(pass_a), p);
    check({tag, "_busy"},      32'(busy_a), 0);
    check({tag, "_err"},       32'(err_count_a), e);
    check({tag, "_fail_addr"}, 32'(fail_addr_a), fa);
    check({tag, "_fail_data"}, 32'(fail_data_a), fd);
  endtask

  // ---------------- directed sequence ----------------
  int n;
  initial begin
    reset_n_a = 1'b0; reset_n_b = 1'b0;
    start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  32'(busy_a), 0);
    check("rst_done",  32'(done_a), 0);
    check("rst_cs",    32'(ram_cs_a), 0);
    check("rst_err",   32'(err_count_a), 0);
    check("rst_state", 32'(dbg_state_a), 0);
    @(negedge clk);
    reset_n_a = 1'b1; reset_n_b = 1'b1;

    // Clean checkerboard run with bus scoreboard
    for (int a = 0; a < 64; a++) exp_q.push_back({6'(a), 8'h55});
    for (int a = 0; a < 64; a++) exp_q.push_back({6'(a), 8'hAA});
    sb_en = 1'b1;
    start_run(1'b0, 2'd0);
    check("t1_busy_at_start", 32'(busy_a), 1);
    check("t1_first_write",   32'({ram_cs_a, ram_wr_en_a, ram_rd_en_a, ram_address_a, ram_data_in_a}),
          32'({3'b110, 6'd0, 8'h55}));
    wait_done(1'b0, 400, n);
    check("t1_done_cycle", n, 258);
    check_result_a("t1", 1, 0, 0, 0);
    sb_en = 1'b0;
    check("t1_reads",    rd_cnt, 128);
    check("t1_overlap",  ovl_cnt, 0);
    check("t1_q_empty",  exp_q.size(), 0);
    check("t1_idle_cs",  32'(ram_cs_a), 0);

    // Stuck bit0 at address 5, all-zeros pattern; restart straight from DONE
    fault_mode = 1;
    start_run(1'b0, 2'd2);
    check("t2_done_fell", 32'(done_a), 0);
    check("t2_busy_rose", 32'(busy_a), 1);
    wait_done(1'b0, 400, n);
    check("t2_done_cycle", n, 258);
    check_result_a("t2", 0, 1, 5, 'h01);

    // data_out forced to FF, all-ones pattern: every second-pass read fails
    fault_mode = 2;
    start_run(1'b0, 2'd3);
    wait_done(1'b0, 400, n);
    check_result_a("t3", 0, 64, 0, 'hFF);

    // Address bit 3 shorted, address-as-data: reads with a[3]=0 return a|8
    fault_mode = 3;
    start_run(1'b0, 2'd1);
    wait_done(1'b0, 400, n);
    check_result_a("t4", 0, 64, 0, 8);

    // Abort mid-RD0, then a clean rerun
    fault_mode = 0;
    start_run(1'b0, 2'd0);
    repeat (69) @(posedge clk);
    #1;
    check("t5_in_rd0", 32'(dbg_state_a), 2);
    abort_a = 1'b1;
    @(posedge clk);
    #1;
    abort_a = 1'b0;
    check("t5_abort_busy",  32'(busy_a), 0);
    check("t5_abort_done",  32'(done_a), 0);
    check("t5_abort_cs",    32'(ram_cs_a), 0);
    check("t5_abort_state", 32'(dbg_state_a), 0);
    check("t5_abort_err",   32'(err_count_a), 0);
    start_run(1'b0, 2'd1);
    wait_done(1'b0, 400, n);
    check("t5_done_cycle", n, 258);
    check_result_a("t5", 1, 0, 0, 0);

    // Unit B: async reset mid-run, then an ignored start, RD_LATENCY=3
    start_run(1'b1, 2'd0);
    repeat (99) @(posedge clk);
    #2;
    check("t6_pre_rst_busy", 32'(busy_b), 1);
    reset_n_b = 1'b0;
    #1;
    check("t6_rst_busy",  32'(busy_b), 0);
    check("t6_rst_done",  32'(done_b), 0);
    check("t6_rst_port",  32'({ram_cs_b, ram_wr_en_b, ram_rd_en_b, ram_address_b, ram_data_in_b}), 0);
    check("t6_rst_state", 32'(dbg_state_b), 0);
    check("t6_rst_err",   32'(err_count_b), 0);
    @(negedge clk);
    reset_n_b = 1'b1;
    start_run(1'b1, 2'd3);
    repeat (49) @(posedge clk);
    #1;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    check("t6_ignored_start_busy", 32'(busy_b), 1);
    wait_done(1'b1, 400, n);
    check("t6_done_cycle", n + 50, 262);
    check("t6_pass", 32'(pass_b), 1);
    check("t6_err",  32'(err_count_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
